descrambler: RTL and testbench
==============================

// Module: descrambler
// PURPOSE
// - Receive-side self-synchronising descrambler for the 10GBASE-R PCS (IEEE 802.3-2012 cl. 49.2.10).
// - Polynomial G(x) = 1 + x^39 + x^58, the inverse of the TX scrambler.
// - Sits between the RX gearbox/block-lock and the 64b/66b decoder.
// - Passes the 2-bit sync header through untouched.
// - Tracks self-synchronisation and flags when output data is guaranteed correct.
// PARAMETERS
// - DATA_WIDTH          32  payload bits per transfer; must divide 64
// - DESCRAMBLER_BYPASS  0   1: data passes through registered, unscrambled; o_locked forced 1
// PORTS
// - i_clk          in   1           clock; all logic on posedge
// - i_reset_n      in   1           reset; asynchronous assert, active-low
// - i_data_valid   in   1           i_data / i_hdr qualifier
// - i_data         in   DATA_WIDTH  scrambled payload; bit 0 received first
// - i_hdr_valid    in   1           i_hdr meaningful; high on the first word of each 66b block
// - i_hdr          in   2           sync header (01 data, 10 control)
// - i_slip         in   1           block-lock bit slip; bit alignment changed
// - o_data_valid   out  1           registered copy of i_data_valid
// - o_data         out  DATA_WIDTH  descrambled payload
// - o_hdr_valid    out  1           registered copy of i_hdr_valid & i_data_valid
// - o_hdr          out  2           registered i_hdr
// - o_locked       out  1           o_data is fully descrambled from received bits
// BEHAVIOUR
// - Async reset state: all outputs 0; lfsr = 58'h3FF_FFFF_FFFF_FFFF (all ones); word_cnt = 0; state = SYNCING.
// - Per bit i = 0..DATA_WIDTH-1 (combinational chain, bit 0 first):
//   - out[i] = in[i] ^ s[38] ^ s[57]
//   - s = {s[56:0], in[i]}. The RECEIVED bit is shifted in, not the output.
// - Latency: 1 clock from an accepted i_data to o_data.
// - Hold on idle: when i_data_valid = 0, lfsr, o_data and o_hdr hold; o_data_valid = 0 and o_hdr_valid = 0.
// - SYNC_WORDS = ceil(58/DATA_WIDTH), which is 2 for DW = 32.
// - FSM:
//   - SYNCING: each accepted word increments word_cnt.
//     - An accepted word with word_cnt == SYNC_WORDS is output with o_locked = 1; state -> SYNCED.
//     - Earlier words are output with o_locked = 0.
//   - SYNCED: o_locked = 1 on every output word.
//   - i_slip = 1 (any state): next cycle o_locked = 0, word_cnt = 0, state -> SYNCING.
//     - The lfsr is NOT cleared, since it self-resynchronises.
//     - i_slip with simultaneous i_data_valid: the word is descrambled, output with o_locked = 0, and counted as word 0 of the new sync.
// - word_cnt saturates at SYNC_WORDS and never wraps.
// - Reset mid-stream: outputs drop to 0 asynchronously; resync requires SYNC_WORDS+1 words again.
// - DESCRAMBLER_BYPASS = 1: o_data = registered i_data; FSM still runs; o_locked = 1 from the first valid word after reset.
// CONFIGURATION
// - Macro DESCRAMBLER_HDR_ERR_CNT_EN:
//   - Defined: adds output o_hdr_err_cnt [7:0], reset 0.
//   - It increments by 1 when i_data_valid & i_hdr_valid & (i_hdr == 2'b00 | i_hdr == 2'b11), and saturates at 8'hFF.
//   - It is cleared to 0 by i_slip; i_slip has priority over increment in the same cycle.
//   - Not defined: the port and counter are absent; header values are never checked.
// TESTING
// - Loopback, both sides seeded all ones:
//   - Drive TX scrambler -> descrambler with 256 random 32b words.
//   - Required: o_data equals the TX input, shifted by TX+RX latency, for every word; o_locked = 0, 0, then 1 from word 2 onward.
// - Seed mismatch (RX lfsr forced to 0 after reset):
//   - Words 0-1 may mismatch.
//   - Word 2 onward must match exactly, with o_locked = 1.
// - Slip mid-stream: assert i_slip for one cycle at word 100.
//   - Required: o_locked = 0 on the next 2 output words, 1 on the 3rd; data stays correct when the slip causes no real misalignment.
// - Valid gaps: i_data_valid pattern 1,0,0,1,1,0,1 on the loopback.
//   - Required: o_data_valid follows it delayed 1 cycle; output data is identical to a gap-free run; o_data holds during gaps.
// - Header passthrough: i_hdr = 2'b10 with i_hdr_valid on word 0.
//   - Required: o_hdr = 2'b10 and o_hdr_valid = 1 one cycle later, aligned with o_data.
//   - With DESCRAMBLER_HDR_ERR_CNT_EN: 300 headers of 2'b11 -> o_hdr_err_cnt = 8'hFF; then i_slip -> 0.
// - Async reset: drop i_reset_n between clock edges mid-stream.
//   - Required: o_data = 0, o_data_valid = 0 and o_locked = 0 immediately.
//   - After release, relock on the 3rd valid word.

Source files
------------

// File: rtl/descrambler.sv
// 10GBASE-R receive descrambler (G(x) = 1 + x^39 + x^58) with self-sync lock tracking.
// Optional header error counter is enabled by defining DESCRAMBLER_HDR_ERR_CNT_EN.
module descrambler #(
    parameter int DATA_WIDTH         = 32,
    parameter bit DESCRAMBLER_BYPASS = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_data_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_hdr_valid,
    input  logic [1:0]            i_hdr,
    input  logic                  i_slip,
    output logic                  o_data_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_hdr_valid,
    output logic [1:0]            o_hdr,
    output logic                  o_locked
`ifdef DESCRAMBLER_HDR_ERR_CNT_EN
    ,
    output logic [7:0]            o_hdr_err_cnt
`endif
);

    localparam int LFSR_W     = 58;
    localparam int SYNC_WORDS = (LFSR_W + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int CNT_W      = $clog2(SYNC_WORDS + 1);
    localparam logic [CNT_W-1:0] SYNC_CNT = CNT_W'(SYNC_WORDS);

    typedef enum logic [0:0] {
        SYNCING = 1'b0,
        SYNCED  = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [CNT_W-1:0]      word_cnt_r;
    logic [CNT_W-1:0]      word_cnt_next_s;
    logic                  locked_next_s;
    logic [LFSR_W-1:0]     lfsr_r;
    logic [LFSR_W-1:0]     lfsr_next_s;
    logic [DATA_WIDTH-1:0] desc_s;

    // Self-synchronising: the received (scrambled) bit is shifted in, so after
    // 58 received bits the state is independent of the seed.
    function automatic logic [LFSR_W+DATA_WIDTH-1:0] descramble(
        input logic [LFSR_W-1:0]     seed,
        input logic [DATA_WIDTH-1:0] din
    );
        logic [LFSR_W-1:0]     s;
        logic [DATA_WIDTH-1:0] d;
        s = seed;
        d = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            d[i] = din[i] ^ s[38] ^ s[57];
            s    = {s[LFSR_W-2:0], din[i]};
        end
        return {s, d};
    endfunction

    // Bit-serial descramble of the whole word in one cycle.
    always_comb begin
        {lfsr_next_s, desc_s} = descramble(lfsr_r, i_data);
    end

    // Lock FSM next state; a slip restarts the count and counts a simultaneous word.
    always_comb begin
        state_next_s    = state_r;
        word_cnt_next_s = word_cnt_r;
        locked_next_s   = o_locked;
        if (i_slip) begin
            state_next_s    = SYNCING;
            locked_next_s   = 1'b0;
            word_cnt_next_s = (i_data_valid && (SYNC_CNT != {CNT_W{1'b0}})) ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (i_data_valid) begin
            case (state_r)
                SYNCING: begin
                    if (word_cnt_r == SYNC_CNT) begin
                        locked_next_s = 1'b1;
                        state_next_s  = SYNCED;
                    end else begin
                        locked_next_s   = 1'b0;
                        word_cnt_next_s = word_cnt_r + CNT_W'(1);
                    end
                end
                SYNCED: begin
                    locked_next_s = 1'b1;
                end
                default: begin
                    state_next_s    = SYNCING;
                    word_cnt_next_s = {CNT_W{1'b0}};
                    locked_next_s   = 1'b0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
        if (DESCRAMBLER_BYPASS) begin
            locked_next_s = i_data_valid ? 1'b1 : o_locked;
        end else begin
            locked_next_s = locked_next_s;
        end
    end

    // FSM state and word counter registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r    <= SYNCING;
            word_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            word_cnt_r <= word_cnt_next_s;
        end
    end

    // Datapath registers; lfsr and data/header hold while idle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr_r       <= {LFSR_W{1'b1}};
            o_data_valid <= 1'b0;
            o_data       <= {DATA_WIDTH{1'b0}};
            o_hdr_valid  <= 1'b0;
            o_hdr        <= 2'b00;
            o_locked     <= 1'b0;
        end else begin
            o_data_valid <= i_data_valid;
            o_hdr_valid  <= i_hdr_valid & i_data_valid;
            o_locked     <= locked_next_s;
            if (i_data_valid) begin
                lfsr_r <= lfsr_next_s;
                o_data <= DESCRAMBLER_BYPASS ? i_data : desc_s;
                o_hdr  <= i_hdr;
            end else begin
                lfsr_r <= lfsr_r;
                o_data <= o_data;
                o_hdr  <= o_hdr;
            end
        end
    end

`ifdef DESCRAMBLER_HDR_ERR_CNT_EN
    logic hdr_err_s;

    // Invalid sync headers are 00 and 11.
    always_comb begin
        hdr_err_s = i_data_valid & i_hdr_valid & ((i_hdr == 2'b00) | (i_hdr == 2'b11));
    end

    // Saturating header error counter; slip clears and wins over increment.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_hdr_err_cnt <= 8'h00;
        end else if (i_slip) begin
            o_hdr_err_cnt <= 8'h00;
        end else if (hdr_err_s && (o_hdr_err_cnt != 8'hFF)) begin
            o_hdr_err_cnt <= o_hdr_err_cnt + 8'h01;
        end else begin
            o_hdr_err_cnt <= o_hdr_err_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_descrambler.sv
// Directed self-checking bench for descrambler: hand vectors, loopback through a
// bench-side TX scrambler, valid gaps, slips, async reset and seed mismatch.
module tb_descrambler;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_data_valid;
    logic [31:0] i_data;
    logic        i_hdr_valid;
    logic [1:0]  i_hdr;
    logic        i_slip;
    logic        o_data_valid;
    logic [31:0] o_data;
    logic        o_hdr_valid;
    logic [1:0]  o_hdr;
    logic        o_locked;
`ifdef DESCRAMBLER_HDR_ERR_CNT_EN
    logic [7:0]  o_hdr_err_cnt;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [57:0] tx_lfsr;
    logic [31:0] plain;
    logic [31:0] scr;
    logic [31:0] last_plain;
    logic        exp_lock;

    descrambler #(.DATA_WIDTH(32), .DESCRAMBLER_BYPASS(1'b0)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_data_valid (i_data_valid),
        .i_data       (i_data),
        .i_hdr_valid  (i_hdr_valid),
        .i_hdr        (i_hdr),
        .i_slip       (i_slip),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .o_hdr_valid  (o_hdr_valid),
        .o_hdr        (o_hdr),
        .o_locked     (o_locked)
`ifdef DESCRAMBLER_HDR_ERR_CNT_EN
        ,
        .o_hdr_err_cnt(o_hdr_err_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // TX side of the loop: scrambled output bit feeds the shift register.
    task automatic scramble(input logic [31:0] d, output logic [31:0] q);
        q = 32'h0;
        for (int i = 0; i < 32; i++) begin
            q[i]    = d[i] ^ tx_lfsr[38] ^ tx_lfsr[57];
            tx_lfsr = {tx_lfsr[56:0], q[i]};
        end
    endtask

    // Called at a negedge: present inputs, clock once, return at the next negedge.
    task automatic drive(input logic v, input logic [31:0] d, input logic hv,
                         input logic [1:0] h, input logic sl);
        i_data_valid = v;
        i_data       = d;
        i_hdr_valid  = hv;
        i_hdr        = h;
        i_slip       = sl;
        @(posedge i_clk);
        @(negedge i_clk);
        i_data_valid = 1'b0;
        i_hdr_valid  = 1'b0;
        i_slip       = 1'b0;
    endtask

    initial begin
        i_reset_n    = 1'b0;
        i_data_valid = 1'b0;
        i_data       = 32'h0;
        i_hdr_valid  = 1'b0;
        i_hdr        = 2'b00;
        i_slip       = 1'b0;
        #3;
        check("rst_data", o_data, 32'h0);
        check("rst_valid", o_data_valid, 1'b0);
        check("rst_hdr_valid", o_hdr_valid, 1'b0);
        check("rst_hdr", o_hdr, 2'b00);
        check("rst_locked", o_locked, 1'b0);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Zero payload with the all-ones seed: bits 39..57 of the stream invert.
        drive(1'b1, 32'h0, 1'b1, 2'b10, 1'b0);
        check("a0_data", o_data, 32'h0000_0000);
        check("a0_valid", o_data_valid, 1'b1);
        check("a0_hdr", o_hdr, 2'b10);
        check("a0_hdr_valid", o_hdr_valid, 1'b1);
        check("a0_locked", o_locked, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 2'b01, 1'b0);
        check("a1_data", o_data, 32'h03FF_FF80);
        check("a1_hdr", o_hdr, 2'b01);
        check("a1_hdr_valid", o_hdr_valid, 1'b0);
        check("a1_locked", o_locked, 1'b0);
        drive(1'b1, 32'h0, 1'b0, 2'b01, 1'b0);
        check("a2_data", o_data, 32'h0000_0000);
        check("a2_locked", o_locked, 1'b1);
        drive(1'b0, 32'hDEAD_BEEF, 1'b1, 2'b11, 1'b0);
        check("idle_valid", o_data_valid, 1'b0);
        check("idle_hdr_valid", o_hdr_valid, 1'b0);
        check("idle_data_hold", o_data, 32'h0000_0000);
        check("idle_hdr_hold", o_hdr, 2'b01);
        check("idle_locked_hold", o_locked, 1'b1);

        // Reset between edges, then loopback with gaps and two kinds of slip.
        #2 i_reset_n = 1'b0;
        #1 check("b_rst_locked", o_locked, 1'b0);
        @(negedge i_clk);
        i_reset_n  = 1'b1;
        tx_lfsr    = {58{1'b1}};
        last_plain = 32'h0;
        for (int w = 0; w < 60; w++) begin
            if (w == 11 || w == 13) begin
                for (int g = 0; g < ((w == 11) ? 2 : 1); g++) begin
                    drive(1'b0, $urandom, 1'b0, 2'b00, 1'b0);
                    check("gap_valid", o_data_valid, 1'b0);
                    check("gap_data_hold", o_data, last_plain);
                end
            end
            if (w == 45) begin
                drive(1'b0, $urandom, 1'b0, 2'b00, 1'b1);
                check("slip_idle_locked", o_locked, 1'b0);
            end
            plain = $urandom;
            scramble(plain, scr);
            drive(1'b1, scr, 1'b0, 2'b00, (w == 30));
            exp_lock = !(w < 2 || w == 30 || w == 31 || w == 45 || w == 46);
            check("lb_valid", o_data_valid, 1'b1);
            check("lb_data", o_data, plain);
            check("lb_locked", o_locked, exp_lock);
            last_plain = plain;
        end

        // Async reset with a word in flight; outputs must drop before the next edge.
        i_data_valid = 1'b1;
        i_data       = $urandom;
        @(posedge i_clk);
        #2 i_reset_n = 1'b0;
        #1;
        check("c_rst_data", o_data, 32'h0);
        check("c_rst_valid", o_data_valid, 1'b0);
        check("c_rst_locked", o_locked, 1'b0);
        i_data_valid = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // TX seed differs from the RX all-ones seed: data is exact from word 2.
        tx_lfsr = 58'h2AA_5555_1234_ABCD;
        for (int w = 0; w < 6; w++) begin
            plain = $urandom;
            scramble(plain, scr);
            drive(1'b1, scr, 1'b0, 2'b01, 1'b0);
            if (w >= 2) begin
                check("seed_data", o_data, plain);
            end
            check("seed_locked", o_locked, (w >= 2));
        end

`ifdef DESCRAMBLER_HDR_ERR_CNT_EN
        check("herr_start", o_hdr_err_cnt, 8'h00);
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, $urandom, 1'b1, 2'b11, 1'b0);
            if (k == 2) begin
                check("herr_three", o_hdr_err_cnt, 8'h03);
            end
        end
        check("herr_sat", o_hdr_err_cnt, 8'hFF);
        drive(1'b1, $urandom, 1'b1, 2'b00, 1'b1);
        check("herr_slip_clear", o_hdr_err_cnt, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
